// File: rtl/if_rom_arbiter.sv
// Arbitrates the single instruction-ROM read port between IF fetch (priority) and debug reads.
// Optional alignment checking is enabled by defining ALIGN_CHECK_EN (adds if_err/dbg_err).
module if_rom_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              stall_req,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_inst
`ifdef ALIGN_CHECK_EN
  ,
  output logic              if_err,
  output logic              dbg_err
`endif
);

  logic              if_elig_s;
  logic              dbg_elig_s;
  logic              starved_s;
  logic              if_gnt_s;
  logic              dbg_gnt_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic              misalign_s;
  logic [DATA_W-1:0] rd_data_s;
  logic [CNT_W-1:0]  cnt_nxt_s;
  logic [CNT_W-1:0]  cnt_r;

  assign if_elig_s  = if_req & ~if_flush;
  assign dbg_elig_s = dbg_req;
  assign starved_s  = (cnt_r == CNT_W'(STARVE_LIMIT));

  // Grant selection: a starved debug request overrides fetch priority.
  always_comb begin
    if_gnt_s  = 1'b0;
    dbg_gnt_s = 1'b0;
    if (dbg_elig_s && starved_s) begin
      dbg_gnt_s = 1'b1;
    end else if (if_elig_s) begin
      if_gnt_s = 1'b1;
    end else if (dbg_elig_s) begin
      dbg_gnt_s = 1'b1;
    end else begin
      if_gnt_s  = 1'b0;
      dbg_gnt_s = 1'b0;
    end
  end

  // ROM address mux and alignment qualification.
  always_comb begin
    sel_addr_s = {ADDR_W{1'b0}};
    misalign_s = 1'b0;
    if (if_gnt_s) begin
      sel_addr_s = if_addr;
    end else if (dbg_gnt_s) begin
      sel_addr_s = dbg_addr;
    end else begin
      sel_addr_s = {ADDR_W{1'b0}};
    end
`ifdef ALIGN_CHECK_EN
    if ((if_gnt_s || dbg_gnt_s) && (sel_addr_s[3:0] != 4'h0)) begin
      misalign_s = 1'b1;
    end else begin
      misalign_s = 1'b0;
    end
`endif
  end

  // Misaligned responses return zero instead of whatever the disabled ROM drives.
  always_comb begin
    rd_data_s = {DATA_W{1'b0}};
    if (misalign_s) begin
      rd_data_s = {DATA_W{1'b0}};
    end else begin
      rd_data_s = rom_inst;
    end
  end

  // Starvation counter: counts consecutive denied debug cycles, saturating at the limit.
  always_comb begin
    cnt_nxt_s = {CNT_W{1'b0}};
    if (dbg_req && !dbg_gnt_s) begin
      if (starved_s) begin
        cnt_nxt_s = cnt_r;
      end else begin
        cnt_nxt_s = cnt_r + CNT_W'(1);
      end
    end else begin
      cnt_nxt_s = {CNT_W{1'b0}};
    end
  end

  assign if_gnt    = if_gnt_s;
  assign dbg_gnt   = dbg_gnt_s;
  assign stall_req = if_elig_s & ~if_gnt_s;
  assign rom_ce    = (if_gnt_s | dbg_gnt_s) & ~misalign_s;
  assign rom_addr  = sel_addr_s;

  // Response registers: winner's data latched one cycle after grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r      <= {CNT_W{1'b0}};
      if_rvalid  <= 1'b0;
      dbg_rvalid <= 1'b0;
      if_rdata   <= {DATA_W{1'b0}};
      dbg_rdata  <= {DATA_W{1'b0}};
`ifdef ALIGN_CHECK_EN
      if_err     <= 1'b0;
      dbg_err    <= 1'b0;
`endif
    end else begin
      cnt_r      <= cnt_nxt_s;
      if_rvalid  <= if_gnt_s;
      dbg_rvalid <= dbg_gnt_s;
      if (if_gnt_s) begin
        if_rdata <= rd_data_s;
      end
      if (dbg_gnt_s) begin
        dbg_rdata <= rd_data_s;
      end
`ifdef ALIGN_CHECK_EN
      if_err     <= if_gnt_s & misalign_s;
      dbg_err    <= dbg_gnt_s & misalign_s;
`endif
    end
  end

endmodule

// File: tb/tb_if_rom_arbiter.sv
// Directed self-checking bench for if_rom_arbiter with a small behavioural ROM.
module tb_if_rom_arbiter;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              stall_req;
  logic              dbg_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;
  logic              rom_ce;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_inst;
`ifdef ALIGN_CHECK_EN
  logic              if_err;
  logic              dbg_err;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  localparam logic [DATA_W-1:0] W00 = 64'h2010_8bff_ffff_fc00;
  localparam logic [DATA_W-1:0] W10 = 64'h2011_9000_0007_2000;
  localparam logic [DATA_W-1:0] W20 = 64'h2012_9800_0004_0800;
  localparam logic [DATA_W-1:0] W30 = 64'h2013_a000_0003_f800;
  localparam logic [DATA_W-1:0] W40 = 64'h0000_0040_ffff_ffbf;

  always #5 clk = ~clk;

  if_rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .stall_req(stall_req),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt),
    .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst)
`ifdef ALIGN_CHECK_EN
    , .if_err(if_err), .dbg_err(dbg_err)
`endif
  );

  function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    case (a)
      64'h00:  rom_word = W00;
      64'h10:  rom_word = W10;
      64'h20:  rom_word = W20;
      64'h30:  rom_word = W30;
      default: rom_word = {a[31:0], ~a[31:0]};
    endcase
  endfunction

  always_comb begin
    rom_inst = 64'h0;
    if (rom_ce) rom_inst = rom_word(rom_addr);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_req = 1'b0; if_flush = 1'b0; dbg_req = 1'b0;
    if_addr = 64'h0; dbg_addr = 64'h0;
  endtask

  task automatic test_reset();
    tests_run++; if (if_rvalid !== 1'b0 || dbg_rvalid !== 1'b0) begin tests_failed++; $display("FAIL reset_rvalid: if=%b dbg=%b expected 0 0", if_rvalid, dbg_rvalid); end
    tests_run++; if (if_rdata !== 64'h0 || dbg_rdata !== 64'h0) begin tests_failed++; $display("FAIL reset_rdata: if=%h dbg=%h expected 0", if_rdata, dbg_rdata); end
    step(); rst = 1'b0;
    // produce a pending fetch response, then reset in the middle of it
    if_req = 1'b1; if_addr = 64'h10;
    step();
    tests_run++; if (if_rvalid !== 1'b1 || if_rdata !== W10) begin tests_failed++; $display("FAIL pre_reset_resp: rvalid=%b rdata=%h expected 1 %h", if_rvalid, if_rdata, W10); end
    #2 rst = 1'b1; idle();
    #1;
    tests_run++; if (if_rvalid !== 1'b0 || if_rdata !== 64'h0 || dbg_rvalid !== 1'b0) begin tests_failed++; $display("FAIL midrun_reset: rvalid=%b rdata=%h dbg_rvalid=%b expected 0 0 0", if_rvalid, if_rdata, dbg_rvalid); end
    step(); rst = 1'b0; #1;
    tests_run++; if (rom_ce !== 1'b0 || stall_req !== 1'b0 || if_gnt !== 1'b0 || dbg_gnt !== 1'b0) begin tests_failed++; $display("FAIL post_reset_idle: ce=%b stall=%b ig=%b dg=%b expected 0 0 0 0", rom_ce, stall_req, if_gnt, dbg_gnt); end
    step();
  endtask

  task automatic test_fetch_only();
    logic [ADDR_W-1:0] addrs [3];
    logic [DATA_W-1:0] exps  [3];
    addrs[0] = 64'h00; addrs[1] = 64'h10; addrs[2] = 64'h20;
    exps[0] = W00; exps[1] = W10; exps[2] = W20;
    for (int i = 0; i < 3; i++) begin
      if_req = 1'b1; if_addr = addrs[i];
      #1;
      tests_run++; if (if_gnt !== 1'b1 || rom_ce !== 1'b1 || rom_addr !== addrs[i] || stall_req !== 1'b0) begin tests_failed++; $display("FAIL fetch_gnt[%0d]: gnt=%b ce=%b addr=%h stall=%b expected 1 1 %h 0", i, if_gnt, rom_ce, rom_addr, stall_req, addrs[i]); end
      step();
      tests_run++; if (if_rvalid !== 1'b1 || if_rdata !== exps[i]) begin tests_failed++; $display("FAIL fetch_resp[%0d]: rvalid=%b rdata=%h expected 1 %h", i, if_rvalid, if_rdata, exps[i]); end
    end
    idle();
    step();
    tests_run++; if (if_rvalid !== 1'b0 || if_rdata !== W20) begin tests_failed++; $display("FAIL fetch_hold: rvalid=%b rdata=%h expected 0 %h", if_rvalid, if_rdata, W20); end
  endtask

  task automatic test_contention();
    if_req = 1'b1; if_addr = 64'h40; dbg_req = 1'b1; dbg_addr = 64'h30;
    for (int c = 1; c <= 5; c++) begin
      #1;
      if (c < 5) begin
        tests_run++; if (if_gnt !== 1'b1 || dbg_gnt !== 1'b0 || stall_req !== 1'b0) begin tests_failed++; $display("FAIL contend_fetch[%0d]: ig=%b dg=%b stall=%b expected 1 0 0", c, if_gnt, dbg_gnt, stall_req); end
      end else begin
        tests_run++; if (if_gnt !== 1'b0 || dbg_gnt !== 1'b1 || stall_req !== 1'b1 || rom_addr !== 64'h30) begin tests_failed++; $display("FAIL contend_dbg: ig=%b dg=%b stall=%b addr=%h expected 0 1 1 30", if_gnt, dbg_gnt, stall_req, rom_addr); end
      end
      step();
      if (c < 5) begin
        tests_run++; if (if_rvalid !== 1'b1 || if_rdata !== W40 || dbg_rvalid !== 1'b0) begin tests_failed++; $display("FAIL contend_fresp[%0d]: rvalid=%b rdata=%h dbg_rvalid=%b expected 1 %h 0", c, if_rvalid, if_rdata, dbg_rvalid, W40); end
      end
    end
    tests_run++; if (dbg_rvalid !== 1'b1 || dbg_rdata !== W30 || if_rvalid !== 1'b0) begin tests_failed++; $display("FAIL contend_dresp: dbg_rvalid=%b dbg_rdata=%h if_rvalid=%b expected 1 %h 0", dbg_rvalid, dbg_rdata, if_rvalid, W30); end
    #1;
    tests_run++; if (if_gnt !== 1'b1 || dbg_gnt !== 1'b0) begin tests_failed++; $display("FAIL contend_cnt_clear: ig=%b dg=%b expected 1 0", if_gnt, dbg_gnt); end
    idle();
    step();
    step();
  endtask

  task automatic test_abandon();
    // three denials, one cycle without debug request (clears count), then a fresh run of four
    if_req = 1'b1; if_addr = 64'h40; dbg_req = 1'b1; dbg_addr = 64'h30;
    step(); step(); step();
    dbg_req = 1'b0;
    step();
    dbg_req = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      #1;
      tests_run++; if (dbg_gnt !== (c == 5) || if_gnt !== (c != 5)) begin tests_failed++; $display("FAIL abandon[%0d]: ig=%b dg=%b expected %b %b", c, if_gnt, dbg_gnt, c != 5, c == 5); end
      step();
    end
    idle();
    step();
  endtask

  task automatic test_flush();
    if_req = 1'b1; if_addr = 64'h20;
    step();
    if_flush = 1'b1; dbg_req = 1'b1; dbg_addr = 64'h10;
    #1;
    tests_run++; if (dbg_gnt !== 1'b1 || if_gnt !== 1'b0 || stall_req !== 1'b0 || rom_addr !== 64'h10) begin tests_failed++; $display("FAIL flush_gnt: dg=%b ig=%b stall=%b addr=%h expected 1 0 0 10", dbg_gnt, if_gnt, stall_req, rom_addr); end
    tests_run++; if (if_rvalid !== 1'b1 || if_rdata !== W20) begin tests_failed++; $display("FAIL flush_prior_resp: rvalid=%b rdata=%h expected 1 %h", if_rvalid, if_rdata, W20); end
    step();
    tests_run++; if (if_rvalid !== 1'b0 || dbg_rvalid !== 1'b1 || dbg_rdata !== W10) begin tests_failed++; $display("FAIL flush_resp: if_rvalid=%b dbg_rvalid=%b dbg_rdata=%h expected 0 1 %h", if_rvalid, dbg_rvalid, dbg_rdata, W10); end
    idle();
    step();
  endtask

  task automatic test_idle_debug();
    dbg_req = 1'b1; dbg_addr = 64'h30;
    #1;
    tests_run++; if (dbg_gnt !== 1'b1 || rom_ce !== 1'b1 || stall_req !== 1'b0 || if_gnt !== 1'b0) begin tests_failed++; $display("FAIL idle_dbg_gnt: dg=%b ce=%b stall=%b ig=%b expected 1 1 0 0", dbg_gnt, rom_ce, stall_req, if_gnt); end
    step();
    tests_run++; if (dbg_rvalid !== 1'b1 || dbg_rdata !== W30) begin tests_failed++; $display("FAIL idle_dbg_resp: rvalid=%b rdata=%h expected 1 %h", dbg_rvalid, dbg_rdata, W30); end
    idle();
    step();
    tests_run++; if (dbg_rvalid !== 1'b0 || dbg_rdata !== W30) begin tests_failed++; $display("FAIL idle_dbg_hold: rvalid=%b rdata=%h expected 0 %h", dbg_rvalid, dbg_rdata, W30); end
  endtask

`ifdef ALIGN_CHECK_EN
  task automatic test_align();
    if_req = 1'b1; if_addr = 64'h08;
    #1;
    tests_run++; if (if_gnt !== 1'b1 || rom_ce !== 1'b0) begin tests_failed++; $display("FAIL align_gnt: ig=%b ce=%b expected 1 0", if_gnt, rom_ce); end
    step();
    tests_run++; if (if_rvalid !== 1'b1 || if_err !== 1'b1 || if_rdata !== 64'h0) begin tests_failed++; $display("FAIL align_resp: rvalid=%b err=%b rdata=%h expected 1 1 0", if_rvalid, if_err, if_rdata); end
    idle();
    step();
    tests_run++; if (if_err !== 1'b0 || dbg_err !== 1'b0) begin tests_failed++; $display("FAIL align_clear: if_err=%b dbg_err=%b expected 0 0", if_err, dbg_err); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    idle();
    #1;
    test_reset();
    test_fetch_only();
    test_contention();
    test_abandon();
    test_flush();
    test_idle_debug();
`ifdef ALIGN_CHECK_EN
    test_align();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/if_rom_arbiter.md
Name: if_rom_arbiter

Overview:
- Shares the single combinational instruction-ROM read port between two requesters.
- Requester 0 is the IF stage fetch port; requester 1 is a debug/loader read port.
- Fetch has fixed priority, with a starvation guard so debug reads eventually win.
- Responses are registered one cycle after grant, and a stall request is raised to pipeline control when fetch loses arbitration.

Parameters:
ADDR_W, 64, width of instruction address bus
DATA_W, 64, width of instruction word
STARVE_LIMIT, 4, consecutive denied debug cycles before debug gets forced priority (1..7)
CNT_W, 3, width of starvation counter; must hold STARVE_LIMIT

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
if_req  in  1  fetch request
if_addr  in  ADDR_W  fetch address
if_flush  in  1  pipeline flush; cancels fetch grant this cycle
if_gnt  out  1  fetch granted this cycle (combinational)
if_rvalid  out  1  fetch response valid (registered)
if_rdata  out  DATA_W  fetch instruction word (registered)
stall_req  out  1  to pipeline control: if_req && !if_flush && !if_gnt
dbg_req  in  1  debug read request
dbg_addr  in  ADDR_W  debug read address
dbg_gnt  out  1  debug granted this cycle (combinational)
dbg_rvalid  out  1  debug response valid (registered)
dbg_rdata  out  DATA_W  debug read data (registered)
rom_ce  out  1  ROM chip enable
rom_addr  out  ADDR_W  ROM address
rom_inst  in  DATA_W  ROM read data (combinational from rom_addr)

Behaviour:
- Reset: async clear of all state.
  - if_rvalid=0, dbg_rvalid=0, if_rdata=0, dbg_rdata=0, starvation counter=0.
  - Combinational outputs follow their requests from the reset values.
- Eligibility:
  - fetch is eligible when if_req && !if_flush.
  - debug is eligible when dbg_req.
- Grant, one per cycle:
  - If debug is eligible and cnt==STARVE_LIMIT, debug wins.
  - Otherwise, if fetch is eligible, fetch wins.
  - Otherwise, if debug is eligible, debug wins.
  - Otherwise, no grant.
- Starvation counter:
  - Increments, saturating at STARVE_LIMIT, when dbg_req && !dbg_gnt.
  - Clears when dbg_gnt is asserted or dbg_req is low.
- ROM port:
  - rom_ce = if_gnt | dbg_gnt.
  - rom_addr = granted requester's address, else 0.
  - When rom_ce=0 the ROM returns 0.
- Response timing:
  - Grant in cycle N latches rom_inst into the winner's rdata at the N/N+1 edge.
  - The winner's rvalid is 1 for cycle N+1 only.
  - A non-granted requester's rvalid is 0 and its rdata holds its previous value.
- Back-to-back: a requester holding req may be granted every cycle, giving one rvalid per cycle with latency 1.
- Requester holds req/addr until gnt; dropping req before gnt is legal and abandons the request.
- if_flush in cycle N: no fetch grant in N and stall_req=0. A fetch rvalid already registered for cycle N is still presented; the IF stage discards it.
- Simultaneous if_req and dbg_req with cnt<STARVE_LIMIT: fetch is granted and the counter increments.
- Reset asserted mid-transaction: any pending rvalid is dropped immediately.

Optional Feature:
- Macro ALIGN_CHECK_EN.
- Defined:
  - A request whose addr[3:0]!=0 is granted normally for arbitration purposes, but rom_ce=0 that cycle.
  - The response in N+1 has rdata=0, rvalid=1, and the added output if_err/dbg_err=1 for that requester.
  - err is registered alongside rvalid and reset to 0.
- Undefined: no alignment check and no err ports; any address is passed to the ROM unchanged.

Test Plan:
- Reset: rst=1 mid-run with if_rvalid=1 -> all rvalid/rdata=0 immediately. After release with no requests: rom_ce=0 and stall_req=0.
- Fetch only: if_req=1 with if_addr=0x00, 0x10, 0x20 in consecutive cycles -> if_gnt=1 each cycle. if_rvalid=1 from the next cycle with if_rdata=0x20108bfffffffc00, 0x2011900000072000, 0x2012980000040800.
- Contention: if_req and dbg_req held, STARVE_LIMIT=4 -> fetch granted 4 cycles with stall_req=0, then debug granted in cycle 5 with stall_req=1. dbg_rvalid=1 in cycle 6 and the counter returns to 0.
- Flush: if_req=1 and dbg_req=1 with if_flush=1 -> dbg_gnt=1, if_gnt=0, stall_req=0, and no if_rvalid next cycle.
- Idle debug: dbg_req=1 alone with dbg_addr=0x30 -> dbg_gnt=1 immediately and dbg_rdata=0x2013a0000003f800 next cycle.
- ALIGN_CHECK_EN: if_addr=0x08 -> rom_ce=0; next cycle if_rvalid=1, if_err=1, if_rdata=0.
